// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer between two CPU stages.
//
// Carries one instruction slot (instr, pc, wreg, NCH data channels of DW bits).
// The upstream and downstream sides use a valid/ready handshake. in_ready is
// driven only from registered state, so downstream back-pressure never creates
// a combinational path back to upstream.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req        exception request: drops all entries, presents an EXC_VECTOR bubble
//   flush      drops all entries, presents an all-zero bubble
//   in_valid   upstream offers a slot
//   in_ready   this stage can accept (no skid entry held)
//   in_instr   instruction word
//   in_pc      instruction pc
//   in_wreg    destination register number
//   in_data    payload; channel k occupies bits [k*DW +: DW]
//   out_valid  output slot valid
//   out_ready  downstream accepts
//   out_instr  registered output fields, same layout as the inputs
//   out_pc
//   out_wreg
//   out_data
//   occ        number of held valid entries (0..2)

module pipe_stage_skid_reg #(
    parameter int unsigned DW         = 32,
    parameter int unsigned NCH        = 3,
    parameter int unsigned RW         = 5,
    parameter logic [31:0] EXC_VECTOR = 32'h00004180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic [RW-1:0]     in_wreg,
    input  logic [NCH*DW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [RW-1:0]     out_wreg,
    output logic [NCH*DW-1:0] out_data,
    output logic [1:0]        occ
);

    localparam int unsigned PW = NCH * DW;

    typedef struct packed {
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [RW-1:0] wreg;
        logic [PW-1:0] data;
    } slot_t;

    // Main entry (drives the outputs) and skid entry.
    slot_t m_q, m_d;
    slot_t s_q, s_d;
    logic  m_valid_q, m_valid_d;
    logic  s_valid_q, s_valid_d;

    slot_t in_slot;
    logic  acc;
    logic  drain;

    assign in_slot = '{instr: in_instr, pc: in_pc, wreg: in_wreg, data: in_data};

    assign in_ready  = ~s_valid_q;
    assign acc       = in_valid & in_ready;
    assign drain     = m_valid_q & out_ready;

    assign out_valid = m_valid_q;
    assign out_instr = m_q.instr;
    assign out_pc    = m_q.pc;
    assign out_wreg  = m_q.wreg;
    assign out_data  = m_q.data;
    assign occ       = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        if (req) begin
            // Bubble carrying the exception vector; the offered slot is squashed.
            m_d       = '0;
            m_d.pc    = EXC_VECTOR;
            s_d       = '0;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (flush) begin
            m_d       = '0;
            s_d       = '0;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || (drain && !s_valid_q)) begin
            // Main slot is free this cycle; an invalid entry keeps stale fields.
            m_valid_d = acc;
            if (acc) begin
                m_d = in_slot;
            end
        end else if (drain) begin
            // Skid is valid here, so in_ready was 0 and acc cannot be set.
            m_d       = s_q;
            m_valid_d = 1'b1;
            s_valid_d = 1'b0;
        end else if (acc) begin
            // Main is stalled: park the new slot in the skid entry.
            s_d       = in_slot;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg.
// Drives an NCH=3 instance and an NCH=1 instance from the same stimulus and
// compares both against a 2-deep FIFO reference model.

module tb_pipe_stage_skid_reg;

    localparam logic [31:0] EXC = 32'h00004180;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  wreg;
        logic [95:0] data;
    } slot_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  in_wreg;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [4:0]  out_wreg;
    logic [95:0] out_data;
    logic [1:0]  occ;

    logic        in_ready1;
    logic        out_valid1;
    logic [31:0] out_instr1;
    logic [31:0] out_pc1;
    logic [4:0]  out_wreg1;
    logic [31:0] out_data1;
    logic [1:0]  occ1;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of held slots (capacity 2) plus the bubble shown
    // after reset/req/flush until a new slot is loaded.
    slot_t q[$];
    slot_t bub;
    bit    bubble;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.DW(32), .NCH(3), .RW(5), .EXC_VECTOR(EXC)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_wreg   (in_wreg),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_wreg  (out_wreg),
        .out_data  (out_data),
        .occ       (occ)
    );

    pipe_stage_skid_reg #(.DW(32), .NCH(1), .RW(5), .EXC_VECTOR(EXC)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_wreg   (in_wreg),
        .in_data   (in_data[31:0]),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_instr (out_instr1),
        .out_pc    (out_pc1),
        .out_wreg  (out_wreg1),
        .out_data  (out_data1),
        .occ       (occ1)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        bub    = '0;
        bubble = 1'b1;
    endtask

    task automatic model_step();
        bit    dr;
        bit    ac;
        slot_t s;
        if (req) begin
            q.delete();
            bub    = '0;
            bub.pc = EXC;
            bubble = 1'b1;
        end else if (flush) begin
            q.delete();
            bub    = '0;
            bubble = 1'b1;
        end else begin
            dr = (q.size() > 0) && out_ready;
            ac = in_valid && (q.size() < 2);
            if (dr) void'(q.pop_front());
            if (ac) begin
                s = '{instr: in_instr, pc: in_pc, wreg: in_wreg, data: in_data};
                q.push_back(s);
                bubble = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        slot_t e;
        check("out_valid", 96'(out_valid), 96'(q.size() > 0));
        check("occ", 96'(occ), 96'(q.size()));
        check("in_ready", 96'(in_ready), 96'(q.size() < 2));
        check("nch1_out_valid", 96'(out_valid1), 96'(q.size() > 0));
        check("nch1_occ", 96'(occ1), 96'(q.size()));
        if (q.size() > 0 || bubble) begin
            e = (q.size() > 0) ? q[0] : bub;
            check("out_instr", 96'(out_instr), 96'(e.instr));
            check("out_pc", 96'(out_pc), 96'(e.pc));
            check("out_wreg", 96'(out_wreg), 96'(e.wreg));
            check("out_data", out_data, e.data);
            check("nch1_out_pc", 96'(out_pc1), 96'(e.pc));
            check("nch1_out_data", 96'(out_data1), 96'(e.data[31:0]));
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic offer(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = $urandom;
        in_wreg  = 5'($urandom);
        in_data  = {$urandom, $urandom, $urandom};
    endtask

    initial begin
        reset     = 1'b0;
        req       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        in_wreg   = '0;
        in_data   = '0;
        model_reset();
        #1;
        check_all();
        check("reset_pc", 96'(out_pc), 96'(0));
        @(negedge clk);
        reset = 1'b1;

        // Streaming at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'h3000 + 32'(4 * i));
            cycle();
            check("stream_pc", 96'(out_pc), 96'(32'h3000 + 32'(4 * i)));
            check("stream_occ", 96'(occ), 96'(1));
            check("stream_in_ready", 96'(in_ready), 96'(1));
        end
        in_valid = 1'b0;
        cycle();

        // Back-pressure fills both entries, then drains in order.
        out_ready = 1'b0;
        offer(32'h3000);
        cycle();
        check("bp_occ1", 96'(occ), 96'(1));
        offer(32'h3004);
        cycle();
        check("bp_occ2", 96'(occ), 96'(2));
        check("bp_full_ready", 96'(in_ready), 96'(0));
        offer(32'h3008);
        cycle();
        check("bp_held_pc", 96'(out_pc), 96'(32'h3000));
        out_ready = 1'b1;
        cycle();
        check("bp_drain1_pc", 96'(out_pc), 96'(32'h3004));
        check("bp_ready_back", 96'(in_ready), 96'(1));
        cycle();
        check("bp_drain2_pc", 96'(out_pc), 96'(32'h3008));
        in_valid = 1'b0;
        cycle();
        check("bp_empty", 96'(occ), 96'(0));

        // Exception while full squashes both entries and the offered slot.
        out_ready = 1'b0;
        offer(32'h3010);
        cycle();
        offer(32'h3014);
        cycle();
        check("exc_pre_occ", 96'(occ), 96'(2));
        offer(32'h3018);
        req = 1'b1;
        cycle();
        check("exc_pc", 96'(out_pc), 96'(EXC));
        check("exc_valid", 96'(out_valid), 96'(0));
        check("exc_data", out_data, 96'(0));
        check("exc_occ", 96'(occ), 96'(0));
        req      = 1'b0;
        in_valid = 1'b0;
        cycle();

        // req outranks flush; flush alone gives a zero bubble.
        offer(32'h3020);
        cycle();
        in_valid = 1'b0;
        req      = 1'b1;
        flush    = 1'b1;
        cycle();
        check("reqflush_pc", 96'(out_pc), 96'(EXC));
        req = 1'b0;
        cycle();
        check("flush_pc", 96'(out_pc), 96'(0));
        check("flush_occ", 96'(occ), 96'(0));
        flush = 1'b0;

        // Channel placement.
        out_ready = 1'b1;
        offer(32'h3030);
        in_data = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        cycle();
        check("ch0", 96'(out_data[31:0]), 96'(32'hAAAA0001));
        check("ch2", 96'(out_data[95:64]), 96'(32'hCCCC0003));
        check("nch1_ch0", 96'(out_data1), 96'(32'hAAAA0001));
        in_valid = 1'b0;
        cycle();

        // Asynchronous reset between edges while full.
        out_ready = 1'b0;
        offer(32'h3040);
        cycle();
        offer(32'h3044);
        cycle();
        check("ar_pre_occ", 96'(occ), 96'(2));
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("ar_valid", 96'(out_valid), 96'(0));
        check("ar_occ", 96'(occ), 96'(0));
        check("ar_pc", 96'(out_pc), 96'(0));
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic with occasional req/flush.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) != 0) offer(32'h4000 + 32'(4 * i));
            else in_valid = 1'b0;
            out_ready = ($urandom_range(2) != 0);
            req       = ($urandom_range(31) == 0);
            flush     = ($urandom_range(31) == 0);
            cycle();
        end
        req      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
